// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - radix-2 DIT FFT sequencer: bit-reversed load, staged butterfly issue, natural-order unload
// Optional feature macro: FFT_SEQ_INVERSE_EN (adds i_inverse / o_tw_conj)
module fft_seq_ctrl #(
    parameter int LOG2N    = 3,
    parameter int BFLY_LAT = 2
) (
    input  logic               i_clk,
    input  logic               i_sclr,
    input  logic               i_start,
    input  logic               i_in_valid,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic               i_inverse,
    output logic               o_tw_conj,
`endif
    output logic               o_in_ready,
    output logic               o_ld_we,
    output logic [LOG2N-1:0]   o_ld_addr,
    output logic               o_bf_valid,
    output logic [LOG2N-1:0]   o_bf_addr_a,
    output logic [LOG2N-1:0]   o_bf_addr_b,
    output logic [LOG2N-2:0]   o_tw_idx,
    output logic [3:0]         o_stage,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [LOG2N-1:0]   o_out_addr,
    output logic               o_busy,
    output logic               o_done
);
    localparam int KW = LOG2N - 1;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'((1 << LOG2N) - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'((1 << KW) - 1);
    localparam logic [3:0]       S_LAST   = 4'(LOG2N - 1);
    localparam logic [3:0]       D_LAST   = 4'(BFLY_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LOG2N-1:0] r_cnt, w_cnt_nxt;
    logic [KW-1:0]    r_k, w_k_nxt;
    logic [3:0]       r_s, w_s_nxt;
    logic [3:0]       r_d, w_d_nxt;

    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_s     <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_s     <= w_s_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_d_nxt     = r_d;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = '0;
            end
            S_LOAD: if (i_in_valid) begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_COMPUTE;
                    w_cnt_nxt   = '0;
                    w_s_nxt     = '0;
                    w_k_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_k_nxt     = '0;
                    w_d_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            // Bubble cycles let the last write-back of a stage land before the next stage reads it.
            S_DRAIN: begin
                if (r_d == D_LAST) begin
                    w_d_nxt = '0;
                    if (r_s == S_LAST) begin
                        w_state_nxt = S_UNLOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_COMPUTE;
                        w_s_nxt     = r_s + 1'b1;
                        w_k_nxt     = '0;
                    end
                end else begin
                    w_d_nxt = r_d + 1'b1;
                end
            end
            S_UNLOAD: if (i_out_ready) begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [LOG2N-1:0] w_kx, w_span, w_mask, w_pos, w_addr_a, w_tw_full, w_bitrev;
    logic             w_in_ready, w_compute, w_stage_on;

    always_comb begin
        w_bitrev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_bitrev[i] = r_cnt[LOG2N-1-i];
        end
    end

    // Butterfly k of stage s: span-aligned group base doubled, plus offset inside the group.
    assign w_kx      = {1'b0, r_k};
    assign w_span    = LOG2N'(1) << r_s;
    assign w_mask    = w_span - 1'b1;
    assign w_pos     = w_kx & w_mask;
    assign w_addr_a  = ((w_kx & ~w_mask) << 1) | w_pos;
    assign w_tw_full = w_pos << (S_LAST - r_s);

    assign w_in_ready  = (r_state == S_LOAD);
    assign w_compute   = (r_state == S_COMPUTE);
    assign w_stage_on  = w_compute || (r_state == S_DRAIN);

    assign o_in_ready  = w_in_ready;
    assign o_ld_we     = i_in_valid & w_in_ready;
    assign o_ld_addr   = w_in_ready ? w_bitrev : '0;
    assign o_bf_valid  = w_compute;
    assign o_bf_addr_a = w_compute ? w_addr_a : '0;
    assign o_bf_addr_b = w_compute ? (w_addr_a | w_span) : '0;
    assign o_tw_idx    = w_compute ? w_tw_full[KW-1:0] : '0;
    assign o_stage     = w_stage_on ? r_s : '0;
    assign o_out_valid = (r_state == S_UNLOAD);
    assign o_out_addr  = (r_state == S_UNLOAD) ? r_cnt : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

`ifdef FFT_SEQ_INVERSE_EN
    logic r_inv;
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_inv <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_inv <= i_inverse;
        end
    end
    assign o_tw_conj = r_inv & w_stage_on;
`endif
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - scoreboard bench for fft_seq_ctrl (N=8, BFLY_LAT=2)
module tb_fft_seq_ctrl;
    localparam int LOG2N    = 3;
    localparam int BFLY_LAT = 2;

    logic       clk = 1'b0;
    logic       sclr, start, in_valid, out_ready, inverse;
    logic       in_ready, ld_we, bf_valid, out_valid, busy, done, tw_conj;
    logic [2:0] ld_addr, bf_addr_a, bf_addr_b, out_addr;
    logic [1:0] tw_idx;
    logic [3:0] stage;

    fft_seq_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(BFLY_LAT)) dut (
        .i_clk       (clk),
        .i_sclr      (sclr),
        .i_start     (start),
        .i_in_valid  (in_valid),
`ifdef FFT_SEQ_INVERSE_EN
        .i_inverse   (inverse),
        .o_tw_conj   (tw_conj),
`endif
        .o_in_ready  (in_ready),
        .o_ld_we     (ld_we),
        .o_ld_addr   (ld_addr),
        .o_bf_valid  (bf_valid),
        .o_bf_addr_a (bf_addr_a),
        .o_bf_addr_b (bf_addr_b),
        .o_tw_idx    (tw_idx),
        .o_stage     (stage),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_addr  (out_addr),
        .o_busy      (busy),
        .o_done      (done)
    );

`ifndef FFT_SEQ_INVERSE_EN
    assign tw_conj = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int a; int b; int tw; int st; int cy;} bf_t;

    int  ld_tab[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int  a_tab[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int  b_tab[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int  tw_tab[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int  ld_q[$];
    bf_t bf_q[$];
    int  out_q[$];
    int  done_q[$];

    int  n_chk = 0, n_fail = 0;
    bit  mon_en = 0;
    int  conj_lo = -1, conj_hi = -1, conj_val = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ld_we"}, ld_we, 0);
        chk({tag, "_ld_addr"}, ld_addr, 0);
        chk({tag, "_bf_valid"}, bf_valid, 0);
        chk({tag, "_bf_a"}, bf_addr_a, 0);
        chk({tag, "_bf_b"}, bf_addr_b, 0);
        chk({tag, "_tw_idx"}, tw_idx, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tw_conj"}, tw_conj, 0);
    endtask

    task automatic push_expect(input int c, input bit timed, input int nbf, input bit full);
        bf_t e;
        for (int i = 0; i < 8; i++) ld_q.push_back(ld_tab[i]);
        for (int j = 0; j < nbf; j++) begin
            e.a  = a_tab[j];
            e.b  = b_tab[j];
            e.tw = tw_tab[j];
            e.st = j / 4;
            e.cy = timed ? c + 9 + 6 * (j / 4) + (j % 4) : -1;
            bf_q.push_back(e);
        end
        if (full) begin
            for (int i = 0; i < 8; i++) out_q.push_back(i);
            done_q.push_back(timed ? c + 35 : -1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ld_we) begin
                if (ld_q.size() == 0) chk("unexpected_ld_we", 1, 0);
                else chk("ld_addr", ld_addr, ld_q.pop_front());
            end
            if (bf_valid) begin
                if (bf_q.size() == 0) chk("unexpected_bf_valid", 1, 0);
                else begin
                    bf_t e;
                    e = bf_q.pop_front();
                    chk("bf_addr_a", bf_addr_a, e.a);
                    chk("bf_addr_b", bf_addr_b, e.b);
                    chk("tw_idx", tw_idx, e.tw);
                    chk("stage", stage, e.st);
                    if (e.cy >= 0) chk("bf_cycle", cyc, e.cy);
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_addr", out_addr, out_q.pop_front());
            end
            if (done) begin
                chk("done_before_unload_end", out_q.size(), 0);
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    int dc;
                    dc = done_q.pop_front();
                    if (dc >= 0) chk("done_cycle", cyc, dc);
                end
            end
`ifdef FFT_SEQ_INVERSE_EN
            chk("tw_conj", tw_conj, (cyc >= conj_lo && cyc <= conj_hi) ? conj_val : 0);
`endif
        end
    end

    task automatic run_xfer(input bit ld_stall, input bit ul_stall, input bit late_start,
                            input bit inv, input bit timed);
        int c, hs, stall_n;
        bit tog, pulsed, seen_done;
        c = cyc;
        push_expect(c, timed, 12, 1);
        if (late_start) begin
            conj_lo = c + 9; conj_hi = c + 26; conj_val = inv;
        end
        start = 1; inverse = inv; out_ready = 1;
        hs = 0; stall_n = 0; tog = 1; pulsed = 0; seen_done = 0;
        for (int i = 0; i < 300 && !seen_done; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
            start = 0;
            if (late_start && out_valid && !pulsed) begin start = 1; pulsed = 1; end
            if (late_start && done) start = 1;
            if (bf_valid) inverse = ~inverse;
            in_valid = in_ready && (ld_stall ? tog : 1'b1);
            if (in_ready) tog = ~tog;
            if (stall_n > 0) begin out_ready = 0; stall_n--; end
            else out_ready = 1;
            if (out_valid && out_ready) begin
                hs++;
                if (ul_stall && hs == 3) stall_n = 3;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        start = 0; in_valid = 0;
        chk("no_restart_after_done", busy, 0);
        @(posedge clk); #1;
        chk("idle_after_done", busy, 0);
        conj_lo = -1; conj_hi = -1; conj_val = 0;
    endtask

    initial begin
        int c;
        sclr = 1; start = 1; in_valid = 0; out_ready = 1; inverse = 0;
        repeat (2) @(posedge clk);
        #1;
        sclr = 0; start = 0;
        chk_zero("rst");
        mon_en = 1;
        @(posedge clk); #1;
        chk("start_ignored_in_sclr", busy, 0);

        run_xfer(0, 0, 0, 0, 1);
        run_xfer(1, 1, 0, 0, 0);

        c = cyc;
        push_expect(c, 1, 7, 0);
        start = 1;
        for (int i = 0; i < 100 && cyc < c + 17; i++) begin
            @(posedge clk); #1;
            start = 0;
            in_valid = (cyc <= c + 8);
        end
        sclr = 1;
        @(posedge clk); #1;
        sclr = 0; in_valid = 0;
        chk("abort_bf_left", bf_q.size(), 0);
        chk("abort_ld_left", ld_q.size(), 0);
        bf_q.delete(); ld_q.delete();
        chk_zero("abort");
        run_xfer(0, 0, 0, 0, 1);

        run_xfer(0, 0, 1, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("ld_q_empty", ld_q.size(), 0);
        chk("bf_q_empty", bf_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Sequencing controller for the in-place radix-2 DIT FFT datapath.
- Accepts N input samples and issues bit-reversed write addresses to the sample RAM.
- Schedules LOG2N stages of N/2 butterflies, with butterfly address pairs and twiddle indices, inserting drain bubbles between stages.
- Reads results out in natural order, then returns to idle.
- Owns all RAM and butterfly sequencing; the butterfly unit and twiddle ROM are slaves.

Parameters:
LOG2N, 3, log2 of FFT length N (N = 2**LOG2N, legal 2..10)
BFLY_LAT, 2, butterfly pipeline latency in cycles: read-to-write-back (legal 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
sclr  in  1  synchronous active-high reset/clear
start  in  1  begin a transform; sampled only in IDLE
in_valid  in  1  input sample present
in_ready  out  1  controller accepts a sample (LOAD state)
ld_we  out  1  RAM write strobe for the loaded sample
ld_addr  out  LOG2N  bit-reversed RAM write address
bf_valid  out  1  butterfly issue strobe
bf_addr_a  out  LOG2N  butterfly top-leg address
bf_addr_b  out  LOG2N  butterfly bottom-leg address
tw_idx  out  LOG2N-1  twiddle ROM index
stage  out  4  current stage number
out_valid  out  1  output sample address valid
out_ready  in  1  downstream accepts output
out_addr  out  LOG2N  natural-order RAM read address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: clocked by clk; sclr is synchronous, active-high.
  - sclr forces state=IDLE and clears all counters.
  - The cycle after sclr, every output is 0.
  - sclr overrides all other inputs, including mid-transform; the partial transform is discarded.
- All outputs are decoded from registered state/counters. No combinational path from any input to any output except in_ready->ld_we gating (ld_we = in_valid & in_ready).
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, DONE.
- IDLE:
  - start=1 -> LOAD, with load count cnt=0.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - ld_addr = bit-reverse(cnt) over LOG2N bits.
  - On in_valid=1: cnt increments.
  - On in_valid=1 with cnt=N-1: -> COMPUTE, s=0, k=0.
  - in_valid=0 stalls with no change.
- COMPUTE:
  - bf_valid=1 every cycle; no backpressure.
  - Per stage s and butterfly k:
    - span = 2**s
    - pos = k mod span
    - grp = k >> s
    - bf_addr_a = (grp << (s+1)) | pos
    - bf_addr_b = bf_addr_a + span
    - tw_idx = pos << (LOG2N-1-s), truncated to LOG2N-1 bits
  - stage = s.
  - k increments each cycle. At k=N/2-1 -> DRAIN with drain count d=0.
- DRAIN:
  - bf_valid=0 for exactly BFLY_LAT cycles, so the last write-back lands before the next stage reads.
  - Then, if s<LOG2N-1: s increments, k=0, -> COMPUTE.
  - Otherwise -> UNLOAD with cnt=0.
- UNLOAD:
  - out_valid=1, out_addr=cnt.
  - On out_ready=1: cnt increments.
  - On out_ready=1 with cnt=N-1: -> DONE.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - start in the DONE cycle is ignored.
- Counter wrap: all counters are width-exact. No counter exceeds its terminal value; terminal value triggers the state change.
- Latency (N=8, BFLY_LAT=2, no stalls):
  - LOAD 8 cycles.
  - COMPUTE+DRAIN 3 x (4+2) = 18 cycles.
  - UNLOAD 8 cycles.
  - DONE 1 cycle.
  - start to done = 35 cycles.

Optional Feature:
FFT_SEQ_INVERSE_EN
- Defined:
  - Adds input port inverse (1 bit) and output port tw_conj (1 bit).
  - inverse is captured when start is accepted in IDLE.
  - tw_conj equals the captured value throughout COMPUTE/DRAIN, and is 0 in all other states and after sclr.
  - Changes to inverse mid-transform have no effect.
- Not defined: neither port exists; the datapath performs forward transforms only.

Test Plan:
1. sclr=1 for 2 cycles, then idle -> all outputs 0; busy=0; start ignored while sclr=1.
2. start, then 8 samples with in_valid held high -> ld_addr sequence 0,4,2,6,1,5,3,7; ld_we high 8 cycles; state enters COMPUTE next cycle.
3. Full transform, N=8, BFLY_LAT=2 -> the following issue pattern, with 2 bf_valid=0 cycles after each stage and done exactly 35 cycles after start:
   - stage0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0
   - stage1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
   - stage2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
4. in_valid toggling 1,0,1,0 and out_ready low for 3 cycles mid-UNLOAD -> counters hold during stalls; out_addr stays 0..7 in order with no skips or repeats; done only after the 8th out handshake.
5. sclr asserted during stage1 COMPUTE (k=2), then new start -> next cycle all outputs 0 and IDLE; the subsequent transform repeats scenario 3 exactly.
6. start pulsed in UNLOAD and DONE cycles; FFT_SEQ_INVERSE_EN defined with inverse=1 at start, toggled mid-run -> no restart; tw_conj=1 across all COMPUTE/DRAIN cycles and 0 elsewhere.
